// File: rtl/fpadd_pkg.sv
// ============================================================================
// Module : fpadd_pkg
// Brief  : Shared widths and the stage-2 -> stage-3 word of the FP32 add pipe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpadd_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 24;
   localparam int EXT_W = MAN_W + 3;

   typedef struct packed {
      logic             bypass;
      logic [31:0]      bypass_result;
      logic             sign_big;
      logic             eff_sub;
      logic [EXP_W-1:0] exp;
      logic [EXT_W-1:0] man_big;
      logic [EXT_W-1:0] man_small;
   } align_word_t;

endpackage

`default_nettype wire

// File: rtl/fpadd_align_shifter.sv
// ============================================================================
// Module : fpadd_align_shifter
// Brief  : Saturating right shift of {man, G, R, S}; sticky OR when
//          FPADD_ALIGN_STICKY_EN is defined, plain truncation otherwise.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_align_shifter
   import fpadd_pkg::*;
(
   input  logic [MAN_W-1:0] i_man,
   input  logic [EXP_W-1:0] i_shamt,
   output logic [EXT_W-1:0] o_aligned
);

   localparam int               SH_W        = $clog2(EXT_W + 1);
   localparam logic [EXP_W-1:0] c_SAT_LIMIT = EXP_W'(EXT_W);

   logic [EXT_W-1:0] w_ext;
   logic             w_sat;
   logic [SH_W-1:0]  w_sh;
   logic [EXT_W-1:0] w_shifted;

   assign w_ext     = {i_man, 3'b000};
   assign w_sat     = (i_shamt >= c_SAT_LIMIT);
   assign w_sh      = i_shamt[SH_W-1:0];
   assign w_shifted = w_sat ? '0 : (w_ext >> w_sh);

`ifdef FPADD_ALIGN_STICKY_EN
   logic [EXT_W-1:0] w_lost_mask;
   logic             w_sticky;

   // Mask selects exactly the low bits that fall off the right end.
   assign w_lost_mask = w_sat ? '1 : ~({EXT_W{1'b1}} << w_sh);
   assign w_sticky    = |(w_ext & w_lost_mask);
   assign o_aligned   = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
`else
   assign o_aligned   = w_shifted;
`endif

endmodule

`default_nettype wire

// File: rtl/fpadd_align_stage.sv
// ============================================================================
// Module : fpadd_align_stage
// Brief  : FP32 add stage 2: operand ordering, mantissa alignment and a
//          2-entry skid-buffered handshake. Option: FPADD_ALIGN_STICKY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_align_stage
   import fpadd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             bypass,
   input  logic [31:0]      bypass_result,
   input  logic             sign_A,
   input  logic             sign_B,
   input  logic [EXP_W-1:0] exp_A,
   input  logic [EXP_W-1:0] exp_B,
   input  logic [MAN_W-1:0] man_A,
   input  logic [MAN_W-1:0] man_B,
   input  logic [EXP_W-1:0] exp_diff,
   input  logic             A_is_bigger,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bypass,
   output logic [31:0]      out_bypass_result,
   output logic             out_sign_big,
   output logic             out_eff_sub,
   output logic [EXP_W-1:0] out_exp,
   output logic [EXT_W-1:0] out_man_big,
   output logic [EXT_W-1:0] out_man_small
);

   logic [MAN_W-1:0] w_man_small;
   logic [EXT_W-1:0] w_aligned;
   align_word_t      w_new;
   logic             w_in_fire;
   logic             w_main_free;

   align_word_t r_main;
   align_word_t r_skid;
   logic        r_main_vld;
   logic        r_skid_vld;

   assign w_man_small = A_is_bigger ? man_B : man_A;

   fpadd_align_shifter u_shifter (
      .i_man     (w_man_small),
      .i_shamt   (exp_diff),
      .o_aligned (w_aligned)
   );

   always_comb begin
      w_new = '0;
      if (bypass) begin
         w_new.bypass        = 1'b1;
         w_new.bypass_result = bypass_result;
      end else begin
         w_new.sign_big  = A_is_bigger ? sign_A : sign_B;
         w_new.eff_sub   = sign_A ^ sign_B;
         w_new.exp       = A_is_bigger ? exp_A : exp_B;
         w_new.man_big   = {(A_is_bigger ? man_A : man_B), 3'b000};
         w_new.man_small = w_aligned;
      end
   end

   // Skid is only ever occupied while main is full, so main being free
   // (empty or draining) is the single condition that advances the queue.
   assign in_ready    = ~r_skid_vld;
   assign w_in_fire   = in_valid & in_ready;
   assign w_main_free = ~r_main_vld | out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main     <= '0;
         r_skid     <= '0;
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (w_main_free) begin
         if (r_skid_vld) begin
            r_main     <= r_skid;
            r_main_vld <= 1'b1;
            r_skid_vld <= 1'b0;
         end else begin
            r_main_vld <= w_in_fire;
            if (w_in_fire) begin
               r_main <= w_new;
            end
         end
      end else if (w_in_fire) begin
         r_skid     <= w_new;
         r_skid_vld <= 1'b1;
      end
   end

   assign out_valid         = r_main_vld;
   assign out_bypass        = r_main.bypass;
   assign out_bypass_result = r_main.bypass_result;
   assign out_sign_big      = r_main.sign_big;
   assign out_eff_sub       = r_main.eff_sub;
   assign out_exp           = r_main.exp;
   assign out_man_big       = r_main.man_big;
   assign out_man_small     = r_main.man_small;

endmodule

`default_nettype wire

// File: tb/tb_fpadd_align_stage.sv
// ============================================================================
// Module : tb_fpadd_align_stage
// Brief  : Directed vector table plus stall, ordering and reset sequences.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpadd_align_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        bypass = 1'b0;
   logic [31:0] bypass_result = '0;
   logic        sign_A = 1'b0, sign_B = 1'b0;
   logic [7:0]  exp_A = '0, exp_B = '0, exp_diff = '0;
   logic [23:0] man_A = '0, man_B = '0;
   logic        A_is_bigger = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_bypass;
   logic [31:0] out_bypass_result;
   logic        out_sign_big;
   logic        out_eff_sub;
   logic [7:0]  out_exp;
   logic [26:0] out_man_big;
   logic [26:0] out_man_small;

   int checks = 0;
   int failures = 0;

   fpadd_align_stage dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .bypass            (bypass),
      .bypass_result     (bypass_result),
      .sign_A            (sign_A),
      .sign_B            (sign_B),
      .exp_A             (exp_A),
      .exp_B             (exp_B),
      .man_A             (man_A),
      .man_B             (man_B),
      .exp_diff          (exp_diff),
      .A_is_bigger       (A_is_bigger),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_bypass        (out_bypass),
      .out_bypass_result (out_bypass_result),
      .out_sign_big      (out_sign_big),
      .out_eff_sub       (out_eff_sub),
      .out_exp           (out_exp),
      .out_man_big       (out_man_big),
      .out_man_small     (out_man_small)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        byp;
      logic [31:0] bres;
      logic        sa, sb;
      logic [7:0]  ea, eb, diff;
      logic [23:0] ma, mb;
      logic        abig;
      logic        e_byp;
      logic [31:0] e_bres;
      logic        e_sign, e_eff;
      logic [7:0]  e_exp;
      logic [26:0] e_big, e_small;
   } vec_t;

   vec_t vecs[$];

`ifdef FPADD_ALIGN_STICKY_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic byp, input logic [31:0] bres,
                      input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [23:0] ma, input logic [23:0] mb, input logic [7:0] diff,
                      input logic abig, input logic e_byp, input logic [31:0] e_bres,
                      input logic e_sign, input logic e_eff, input logic [7:0] e_exp,
                      input logic [26:0] e_big, input logic [26:0] e_small);
      vec_t v;
      v.name = nm; v.byp = byp; v.bres = bres; v.sa = sa; v.sb = sb;
      v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb; v.diff = diff; v.abig = abig;
      v.e_byp = e_byp; v.e_bres = e_bres; v.e_sign = e_sign; v.e_eff = e_eff;
      v.e_exp = e_exp; v.e_big = e_big; v.e_small = e_small;
      vecs.push_back(v);
   endtask

   task automatic set_word(input int k);
      bypass = 1'b0; bypass_result = '0; sign_A = 1'b0; sign_B = 1'b0;
      exp_A = 8'(100 + k); exp_B = 8'd0; exp_diff = 8'(100 + k);
      man_A = 24'h800000 + 24'(k); man_B = '0; A_is_bigger = 1'b1;
   endtask

   logic fire_in;
   int   k_in;
   int   n_rx;
   logic [7:0] rx_exp[4];
   logic [26:0] rx_big[4];

   initial begin
      // ---------------- reset state ----------------
      #1;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset out_exp", 64'(out_exp), 64'd0);
      chk("reset out_man_big", 64'(out_man_big), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- vector table ----------------
      //   name         byp bres          sA sB eA    eB    mA          mB          diff  aBig | byp ebres sgn eff exp  big           small
      add("t1 basic",   0, 32'hDEADBEEF, 0, 0, 8'd130, 8'd127, 24'h800000, 24'hC00000, 8'd3, 1, 0, 0, 0, 0, 8'd130, 27'h4000000, 27'h0C00000);
      add("t2 b big",   0, 32'h0,        0, 1, 8'd130, 8'd127, 24'h800000, 24'hC00000, 8'd3, 0, 0, 0, 1, 1, 8'd127, 27'h6000000, 27'h0800000);
      add("t3 sat30",   0, 32'h0,        1, 1, 8'd160, 8'd130, 24'h800000, 24'hFFFFFF, 8'd30, 1, 0, 0, 1, 0, 8'd160, 27'h4000000, {26'd0, STK});
      add("t4 bypass",  1, 32'h7FC00000, 1, 0, 8'd130, 8'd127, 24'h800000, 24'hC00000, 8'd3, 1, 1, 32'h7FC00000, 0, 0, 8'd0, 27'h0, 27'h0);
      add("diff0",      0, 32'h0,        0, 0, 8'd127, 8'd127, 24'hA00000, 24'h900000, 8'd0, 1, 0, 0, 0, 0, 8'd127, 27'h5000000, 27'h4800000);
      add("lost bits",  0, 32'h0,        0, 0, 8'd135, 8'd130, 24'h800000, 24'h800001, 8'd5, 1, 0, 0, 0, 0, 8'd135, 27'h4000000, {26'h0100000, STK});
      add("exact d3",   0, 32'h0,        0, 0, 8'd133, 8'd130, 24'h800000, 24'h800001, 8'd3, 1, 0, 0, 0, 0, 8'd133, 27'h4000000, 27'h0800001);
      add("diff26",     0, 32'h0,        0, 1, 8'd30,  8'd56,  24'h800000, 24'h900000, 8'd26, 0, 0, 0, 1, 1, 8'd56, 27'h4800000, 27'h0000001);
      add("diff27",     0, 32'h0,        1, 0, 8'd157, 8'd130, 24'h900000, 24'h800000, 8'd27, 1, 0, 0, 1, 1, 8'd157, 27'h4800000, {26'd0, STK});
      add("diff255",    0, 32'h0,        0, 0, 8'd255, 8'd0,   24'h800000, 24'h000001, 8'd255, 1, 0, 0, 0, 0, 8'd255, 27'h4000000, {26'd0, STK});
      add("subnormal",  0, 32'h0,        0, 0, 8'd0,   8'd0,   24'h400000, 24'h200000, 8'd0, 1, 0, 0, 0, 0, 8'd0, 27'h2000000, 27'h1000000);

      out_ready = 1'b1;
      foreach (vecs[i]) begin
         bypass = vecs[i].byp; bypass_result = vecs[i].bres;
         sign_A = vecs[i].sa; sign_B = vecs[i].sb;
         exp_A = vecs[i].ea; exp_B = vecs[i].eb; exp_diff = vecs[i].diff;
         man_A = vecs[i].ma; man_B = vecs[i].mb; A_is_bigger = vecs[i].abig;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk({vecs[i].name, " valid"}, 64'(out_valid), 64'd1);
         chk({vecs[i].name, " bypass"}, 64'(out_bypass), 64'(vecs[i].e_byp));
         chk({vecs[i].name, " bres"}, 64'(out_bypass_result), 64'(vecs[i].e_bres));
         chk({vecs[i].name, " sign"}, 64'(out_sign_big), 64'(vecs[i].e_sign));
         chk({vecs[i].name, " effsub"}, 64'(out_eff_sub), 64'(vecs[i].e_eff));
         chk({vecs[i].name, " exp"}, 64'(out_exp), 64'(vecs[i].e_exp));
         chk({vecs[i].name, " man_big"}, 64'(out_man_big), 64'(vecs[i].e_big));
         chk({vecs[i].name, " man_small"}, 64'(out_man_small), 64'(vecs[i].e_small));
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("drained valid", 64'(out_valid), 64'd0);

      // ---------------- stall: 4 cycles of back-pressure ----------------
      out_ready = 1'b0;
      k_in = 0;
      set_word(0);
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         fire_in = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (fire_in) begin
            k_in++;
            set_word(k_in);
         end
         if (c == 1) chk("skid full in_ready", 64'(in_ready), 64'd0);
      end
      chk("stall accepted count", 64'(k_in), 64'd2);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      chk("stall out_valid", 64'(out_valid), 64'd1);
      chk("stall out_exp stable", 64'(out_exp), 64'd100);

      out_ready = 1'b1;
      n_rx = 0;
      for (int c = 0; c < 20 && n_rx < 4; c++) begin
         fire_in = in_valid && in_ready;
         if (out_valid && out_ready) begin
            rx_exp[n_rx] = out_exp;
            rx_big[n_rx] = out_man_big;
            n_rx++;
         end
         @(posedge clk);
         #1;
         if (fire_in) begin
            k_in++;
            if (k_in < 4) set_word(k_in);
            else in_valid = 1'b0;
         end
      end
      chk("order rx count", 64'(n_rx), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < n_rx) begin
            chk($sformatf("order exp W%0d", k), 64'(rx_exp[k]), 64'(100 + k));
            chk($sformatf("order man W%0d", k), 64'(rx_big[k]), 64'({24'h800000 + 24'(k), 3'b000}));
         end
      end
      chk("order no duplicate", 64'(out_valid), 64'd0);

      // ---------------- async reset with both entries full ----------------
      out_ready = 1'b0;
      set_word(0);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      set_word(1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("prefill in_ready", 64'(in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 64'(out_valid), 64'd0);
      chk("async rst in_ready", 64'(in_ready), 64'd1);
      chk("async rst out_exp", 64'(out_exp), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      set_word(5);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("post rst valid", 64'(out_valid), 64'd1);
      chk("post rst exp", 64'(out_exp), 64'd105);
      @(posedge clk);
      #1;
      chk("post rst flushed", 64'(out_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
